// File: rtl/address_pkg.sv
// address_pkg: shared VGA geometry and tile-address widths for the 2048 display path
package address_pkg;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int TILE_LOG2 = 6;
  localparam int TILE      = 1 << TILE_LOG2;
  localparam int COL_W     = 10;
  localparam int ROW_W     = 9;
  localparam int ADDR_W    = 2 * TILE_LOG2;
  typedef logic [COL_W-1:0]  col_t;
  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/address_if.sv
// address_if: scan coordinates in, registered tile ROM address out
interface address_if;
  import address_pkg::*;
  col_t  col_addr;
  row_t  row_addr;
  addr_t addr;
  logic  addr_valid;
  modport master (output col_addr, row_addr, input addr, addr_valid);
  modport slave  (input col_addr, row_addr, output addr, addr_valid);
endinterface

// File: rtl/address.sv
// address: maps VGA scan coordinates to a registered 64x64 tile ROM address
module address
  import address_pkg::*;
#(
  parameter int X0        = 0,
  parameter int Y0        = 0,
  parameter int TILE_LOG2 = address_pkg::TILE_LOG2
) (
  input logic       clk,
  input logic       rst_n,
  address_if.slave  bus
);
  localparam int SIDE = 1 << TILE_LOG2;
  col_t local_col;
  col_t local_row;
  logic in_win;
  logic [2*TILE_LOG2-1:0] addr_q;
  logic valid_q;
  // once the coordinate is at or past the origin the subtraction cannot wrap,
  // so the far-edge test reduces to the local offset being below the tile side
  always_comb begin
    local_col = bus.col_addr - COL_W'(X0);
    local_row = COL_W'(bus.row_addr) - COL_W'(Y0);
    in_win = (int'(bus.col_addr) >= X0) && (int'(local_col) < SIDE) &&
             (int'(bus.row_addr) >= Y0) && (int'(local_row) < SIDE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= in_win ? {local_row[TILE_LOG2-1:0], local_col[TILE_LOG2-1:0]} : '0;
      valid_q <= in_win;
    end
  end
  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
endmodule

// File: tb/tb_address.sv
// tb_address: scoreboard bench for two address instances (default and offset window)
module tb_address;
  typedef struct {int a; bit v; int c; int r;} exp_t;
  logic clk = 0;
  logic rst_n = 0;
  int errors = 0;
  int checks = 0;
  exp_t q0[$];
  exp_t q1[$];
  address_if i0();
  address_if i1();
  address #(.X0(0),   .Y0(0))  u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  address #(.X0(100), .Y0(50)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  always #10 clk = ~clk;
  function automatic exp_t model(int c, int r, int x0, int y0, bit rn);
    exp_t e;
    bit in;
    in = rn && c >= x0 && c < x0 + 64 && r >= y0 && r < y0 + 64;
    e.v = in;
    e.a = in ? (r - y0) * 64 + (c - x0) : 0;
    e.c = c;
    e.r = r;
    return e;
  endfunction
  task automatic drive(int c, int r, bit rn);
    @(posedge clk);
    #2;
    i0.col_addr = 10'(c);
    i0.row_addr = 9'(r);
    i1.col_addr = 10'(c);
    i1.row_addr = 9'(r);
    rst_n = rn;
    q0.push_back(model(c, r, 0, 0, rn));
    q1.push_back(model(c, r, 100, 50, rn));
  endtask
  task automatic chk(string n, exp_t e, int a, bit v);
    checks += 2;
    if (a != e.a) begin
      errors++;
      $display("FAIL %s addr col=%0d row=%0d got=%0d want=%0d", n, e.c, e.r, a, e.a);
    end
    if (v != e.v) begin
      errors++;
      $display("FAIL %s addr_valid col=%0d row=%0d got=%0d want=%0d", n, e.c, e.r, v, e.v);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("dut0", e, int'(i0.addr), i0.addr_valid);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("dut1", e, int'(i1.addr), i1.addr_valid);
    end
  end
  initial begin
    int c, r;
    bit rn;
    repeat (3) drive(5, 5, 0);
    drive(5, 5, 1);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        drive(x, y, !(x == 10 && y == 10));
    drive(64, 2, 1);
    drive(0, 3, 1);
    drive(10, 64, 1);
    drive(639, 479, 1);
    drive(100, 50, 1);
    drive(163, 113, 1);
    drive(99, 50, 1);
    drive(164, 60, 1);
    drive(120, 114, 1);
    drive(1023, 511, 1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        c = $urandom_range(0, 1023);
        r = $urandom_range(0, 511);
      end else begin
        c = $urandom_range(90, 175);
        r = $urandom_range(40, 125);
      end
      rn = ($urandom_range(0, 31) != 0);
      drive(c, r, rn);
    end
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q0.size() + q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
